// File: rtl/regfile_sb.sv
// Parametrised register file with a post-reset clear walk and a pending-write scoreboard for RAW hazard detection.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int  N_Bits = 32,
    parameter int  N_Regs = 32,
    localparam int A_Bits = $clog2(N_Regs)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [A_Bits-1:0] A1,
    input  logic [A_Bits-1:0] A2,
    input  logic [A_Bits-1:0] A3,
    input  logic [N_Bits-1:0] WD3,
    input  logic              WE3,
    output logic [N_Bits-1:0] RD1,
    output logic [N_Bits-1:0] RD2,
    input  logic              issue_valid,
    input  logic [A_Bits-1:0] issue_rd,
    output logic              busy1,
    output logic              busy2,
    output logic              ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [A_Bits-1:0] clr_idx;
    logic [N_Bits-1:0] regs [N_Regs];
    logic [N_Regs-1:0] pending;
    logic              run;

    assign run = (state == RUN);

    // rst only restarts the walk; register contents are zeroed one per cycle by CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
            pending <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 1'b1;
                    if (clr_idx == A_Bits'(N_Regs - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (WE3 && A3 != '0) begin
                        regs[A3] <= WD3;
                    end
                    // A new producer supersedes a retiring one on the same register.
                    for (int r = 1; r < N_Regs; r++) begin
                        if (issue_valid && issue_rd == A_Bits'(r)) begin
                            pending[r] <= 1'b1;
                        end else if (WE3 && A3 == A_Bits'(r)) begin
                            pending[r] <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    always_comb begin
        RD1 = '0;
        RD2 = '0;
        if (run && A1 != '0) begin
            RD1 = regs[A1];
        end
        if (run && A2 != '0) begin
            RD2 = regs[A2];
        end
`ifdef REGFILE_BYPASS_EN
        if (run && WE3 && A3 != '0 && A3 == A1) begin
            RD1 = WD3;
        end
        if (run && WE3 && A3 != '0 && A3 == A2) begin
            RD2 = WD3;
        end
`endif
    end

    always_comb begin
        busy1 = run && (A1 != '0) && pending[A1];
        busy2 = run && (A2 != '0) && pending[A2];
`ifdef REGFILE_BYPASS_EN
        if (WE3 && A3 == A1) begin
            busy1 = 1'b0;
        end
        if (WE3 && A3 == A2) begin
            busy2 = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: random and directed stimulus against an array-based model of the register file.
// Build with REGFILE_BYPASS_EN defined to check the forwarding variant.
module tb_regfile_sb;

    localparam int NR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a1, a2, a3, issue_rd;
    logic [31:0] wd3;
    logic        we3, issue_valid;
    logic [31:0] rd1, rd2;
    logic        busy1, busy2, ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_regs [NR];
    bit          m_pend [NR];
    bit          m_ready;
    int          m_cnt;

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .A1(a1), .A2(a2), .A3(a3), .WD3(wd3), .WE3(we3),
        .RD1(rd1), .RD2(rd2),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .busy1(busy1), .busy2(busy2), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!m_ready || a == 0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we3 && a3 == a) return wd3;
`endif
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        logic b;
        if (!m_ready || a == 0) return 1'b0;
        b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
        if (we3 && a3 == a) b = 1'b0;
`endif
        return b;
    endfunction

    // Advance one clock; the model consumes the inputs that were stable across the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            m_ready = 1'b0;
            m_cnt   = 0;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_regs[m_cnt] = 32'h0;
            m_cnt++;
            if (m_cnt == NR) m_ready = 1'b1;
        end else begin
            for (int r = 1; r < NR; r++) begin
                if (issue_valid && issue_rd == 5'(r)) m_pend[r] = 1'b1;
                else if (we3 && a3 == 5'(r)) m_pend[r] = 1'b0;
            end
            if (we3 && a3 != 0) m_regs[a3] = wd3;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; we3 = 1'b0; issue_valid = 1'b0;
        a3 = 5'd0; wd3 = 32'h0; issue_rd = 5'd0;
    endtask

    task automatic test_reset();
        idle_inputs();
        a1 = 5'd0; a2 = 5'd0;
        foreach (m_regs[i]) m_regs[i] = 'x;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            we3 = 1'($urandom); a3 = 5'($urandom); wd3 = $urandom;
            issue_valid = 1'($urandom); issue_rd = 5'($urandom);
            a1 = 5'($urandom); a2 = 5'($urandom);
            #1;
            checks++;
            if (ready !== 1'b0) begin
                errors++; $display("[TB] FAIL clear_ready cyc=%0d: got %b expected 0", i, ready);
            end
            checks++;
            if (rd1 !== 32'h0 || busy1 !== 1'b0) begin
                errors++; $display("[TB] FAIL clear_rd1 cyc=%0d: got rd=%h busy=%b expected 0/0", i, rd1, busy1);
            end
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ready !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_rise: got %b expected 1", ready);
        end
    endtask

    task automatic test_clear_preload();
        for (int i = 1; i < NR; i++) begin
            we3 = 1'b1; a3 = 5'(i); wd3 = 32'hFFFF_FFFF;
            tick();
        end
        idle_inputs();
        for (int i = 1; i < NR; i++) begin
            a1 = 5'(i); a2 = 5'(i) ^ 5'h1f;
            #1;
            checks++;
            if (rd1 !== 32'hFFFF_FFFF || rd2 !== exp_rd(a2)) begin
                errors++; $display("[TB] FAIL preload r%0d: got %h/%h expected ffffffff/%h", i, rd1, rd2, exp_rd(a2));
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < NR; i++) begin
            we3 = 1'b1; a3 = 5'($urandom); wd3 = $urandom;
            issue_valid = 1'b1; issue_rd = 5'($urandom);
            a1 = 5'(i); a2 = 5'($urandom);
            #1;
            checks++;
            if (ready !== 1'b0 || rd1 !== 32'h0 || rd2 !== 32'h0) begin
                errors++; $display("[TB] FAIL clear_walk cyc=%0d: got ready=%b rd=%h/%h expected 0", i, ready, rd1, rd2);
            end
            tick();
        end
        idle_inputs();
        for (int i = 1; i < NR; i++) begin
            a1 = 5'(i); a2 = 5'(NR - i);
            #1;
            checks++;
            if (ready !== 1'b1 || rd1 !== 32'h0 || rd2 !== 32'h0 || busy1 !== 1'b0) begin
                errors++; $display("[TB] FAIL cleared r%0d: got ready=%b rd=%h/%h busy=%b expected 1/0/0/0", i, ready, rd1, rd2, busy1);
            end
            tick();
        end
    endtask

    task automatic test_write_read();
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEAD_BEEF; a1 = 5'd5;
        #1;
        checks++;
        if (rd1 !== exp_rd(5'd5)) begin
            errors++; $display("[TB] FAIL write_same_cycle: got %h expected %h", rd1, exp_rd(5'd5));
        end
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'hDEAD_BEEF) begin
            errors++; $display("[TB] FAIL write_read: got %h expected deadbeef", rd1);
        end
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234; a1 = 5'd0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++; $display("[TB] FAIL x0_during_write: got %h expected 0", rd1);
        end
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'h0) begin
            errors++; $display("[TB] FAIL x0_after_write: got %h expected 0", rd1);
        end
    endtask

    task automatic test_scoreboard();
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b1; issue_rd = 5'd0;
        tick();
        issue_valid = 1'b0;
        a2 = 5'd7; a1 = 5'd0;
        #1;
        checks++;
        if (busy2 !== 1'b1 || busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_set: got busy2=%b busy1=%b expected 1/0", busy2, busy1);
        end
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h7777_0007;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (busy2 !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_write_cycle: got %b expected 0", busy2);
        end
`else
        if (busy2 !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_write_cycle: got %b expected 1", busy2);
        end
`endif
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (busy2 !== 1'b0 || rd2 !== 32'h7777_0007) begin
            errors++; $display("[TB] FAIL busy_cleared: got busy=%b rd=%h expected 0/77770007", busy2, rd2);
        end
    endtask

    task automatic test_set_beats_clear();
        logic [31:0] d;
        d = $urandom;
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        we3 = 1'b1; a3 = 5'd9; wd3 = d;
        tick();
        idle_inputs();
        a1 = 5'd9; a2 = 5'd9;
        #1;
        checks++;
        if (busy1 !== 1'b1 || busy2 !== 1'b1 || rd1 !== d || rd2 !== d) begin
            errors++; $display("[TB] FAIL set_beats_clear: got busy=%b/%b rd=%h/%h expected 1/1 %h", busy1, busy2, rd1, rd2, d);
        end
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        issue_valid = 1'b0; we3 = 1'b1; a3 = 5'd9; wd3 = 32'h0;
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL single_bit_pending: got %b expected 0", busy1);
        end
    endtask

    task automatic test_bypass();
        we3 = 1'b1; a3 = 5'd3; wd3 = 32'h1;
        tick();
        a1 = 5'd3; a2 = 5'd3; wd3 = 32'hA5A5_A5A5;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (rd1 !== 32'hA5A5_A5A5 || rd2 !== rd1) begin
            errors++; $display("[TB] FAIL bypass_cycle: got %h/%h expected a5a5a5a5", rd1, rd2);
        end
`else
        if (rd1 !== 32'h1 || rd2 !== 32'h1) begin
            errors++; $display("[TB] FAIL bypass_cycle: got %h/%h expected 00000001", rd1, rd2);
        end
`endif
        tick();
        we3 = 1'b0;
        #1;
        checks++;
        if (rd1 !== 32'hA5A5_A5A5) begin
            errors++; $display("[TB] FAIL bypass_next: got %h expected a5a5a5a5", rd1);
        end
    endtask

    task automatic test_reset_midrun();
        we3 = 1'b1; a3 = 5'd4; wd3 = 32'h55;
        tick();
        we3 = 1'b0; issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        issue_valid = 1'b0; a1 = 5'd4;
        #1;
        checks++;
        if (rd1 !== 32'h55 || busy1 !== 1'b1) begin
            errors++; $display("[TB] FAIL pre_reset r4: got %h busy=%b expected 55/1", rd1, busy1);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b0 || busy1 !== 1'b0 || rd1 !== 32'h0) begin
            errors++; $display("[TB] FAIL midrun_reset: got ready=%b busy=%b rd=%h expected 0/0/0", ready, busy1, rd1);
        end
        for (int i = 0; i < NR; i++) begin
            we3 = 1'b1; a3 = 5'd4; wd3 = $urandom;
            issue_valid = 1'b1; issue_rd = 5'd4;
            tick();
        end
        idle_inputs();
        #1;
        checks++;
        if (ready !== 1'b1 || rd1 !== 32'h0 || busy1 !== 1'b0) begin
            errors++; $display("[TB] FAIL post_clear r4: got ready=%b rd=%h busy=%b expected 1/0/0", ready, rd1, busy1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            we3 = 1'($urandom); a3 = 5'($urandom_range(0, 7)); wd3 = $urandom;
            issue_valid = 1'($urandom); issue_rd = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7)); a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 7));
            #1;
            checks++;
            if (rd1 !== exp_rd(a1) || rd2 !== exp_rd(a2)) begin
                errors++; $display("[TB] FAIL rand_rd cyc=%0d a=%0d/%0d: got %h/%h expected %h/%h", i, a1, a2, rd1, rd2, exp_rd(a1), exp_rd(a2));
            end
            checks++;
            if (busy1 !== exp_busy(a1) || busy2 !== exp_busy(a2) || ready !== m_ready) begin
                errors++; $display("[TB] FAIL rand_flags cyc=%0d: got busy=%b/%b ready=%b expected %b/%b/%b", i, busy1, busy2, ready, exp_busy(a1), exp_busy(a2), m_ready);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_clear_preload();
        test_write_read();
        test_scoreboard();
        test_set_beats_clear();
        test_bypass();
        test_reset_midrun();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined core.
- Provides configurable width and depth, 2 async read ports and 1 sync write port.
- After reset, a sequenced clear FSM zeroes every register, and a per-register pending-write scoreboard flags RAW hazards to the decode stage.
- Sits between decode (reads, issue), writeback (writes) and the hazard unit (busy flags).

Parameters:
- N_Bits, 32, data width of each register.
- N_Regs, 32, number of architectural registers; power of 2, >=2.
- A_Bits, $clog2(N_Regs), address width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- A1  input  A_Bits  read address, port 1.
- A2  input  A_Bits  read address, port 2.
- A3  input  A_Bits  write address.
- WD3  input  N_Bits  write data.
- WE3  input  1  write enable.
- RD1  output  N_Bits  read data, port 1 (combinational).
- RD2  output  N_Bits  read data, port 2 (combinational).
- issue_valid  input  1  decode issues an instruction that will write issue_rd.
- issue_rd  input  A_Bits  destination of the issued instruction.
- busy1  output  1  pending write outstanding on A1.
- busy2  output  1  pending write outstanding on A2.
- ready  output  1  clear sequence complete; block accepts traffic.

Behaviour:
- Reset (rst=1 at posedge):
  - state=CLEAR, clr_idx=0, ready=0, pending[all]=0.
  - Register contents are not touched by rst itself; the CLEAR walk zeroes them.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each posedge with rst=0: registers[clr_idx]<=0 and clr_idx++.
  - When clr_idx==N_Regs-1: next state RUN, ready<=1.
  - ready therefore rises after the N_Regs-th posedge with rst=0 (32 cycles at default).
  - WE3 and issue_valid are ignored.
  - RD1/RD2 read 0; busy1/busy2 read 0.
- RUN:
  - Normal operation; ready stays 1 until next rst.
  - rst mid-operation restarts the CLEAR sequence from index 0 and drops pending state.
- Register 0:
  - Hardwired zero; writes to 0 are dropped.
  - issue_rd==0 never sets pending; busy for address 0 is always 0.
- Write: WE3=1 and A3!=0 at posedge -> registers[A3]<=WD3; visible on RD the following cycle (zero-latency visibility only with the optional feature).
- Read: RDn = (An==0) ? 0 : registers[An]; purely combinational from address.
- Scoreboard, per register r!=0, updated at posedge in RUN:
  - Set: issue_valid && issue_rd==r.
  - Clear: WE3 && A3==r.
  - Set and clear on the same r in the same cycle -> set wins (new producer supersedes the retiring one).
  - Set on an already-pending r -> stays pending (single bit; no counting).
  - Write to a non-pending r -> register updated, pending unchanged (0).
- Combinational busy flags: busyn = pending[An] (modified by the bypass feature below).
- Both read ports addressing the same register -> identical RD and busy values.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-to-read forwarding):
  - If WE3 && A3!=0 && A3==An in RUN, then RDn=WD3 in the same cycle.
  - busyn = pending[An] && !(WE3 && A3==An).
- Undefined:
  - RDn shows the old value during the write cycle.
  - busyn = pending[An] regardless of a same-cycle write.

Test Plan:
- Reset/clear:
  - Preload all regs to 0xFFFFFFFF via a backdoor, pulse rst for 1 cycle.
  - Required: ready=0 for 32 posedges, then 1.
  - Required: all 31 regs then read 0x00000000, and RD=0 during CLEAR.
- Write/read plus x0:
  - WE3=1, A3=5, WD3=0xDEADBEEF; then A1=5 -> RD1=0xDEADBEEF next cycle.
  - WE3=1, A3=0, WD3=0x1234 -> RD1 at A1=0 stays 0.
- Scoreboard:
  - issue_valid=1, issue_rd=7; next cycle A2=7 -> busy2=1.
  - WE3=1, A3=7 -> busy2=0 after the posedge (same cycle if REGFILE_BYPASS_EN).
- Set-beats-clear:
  - pending[9]=1; same cycle issue_rd=9 and WE3 with A3=9 -> pending[9] remains 1 and reg9 holds WD3.
- Bypass (both builds):
  - A1=A3=3, WE3=1, WD3=0xA5A5A5A5, reg3 old=0x1.
  - With macro: RD1=0xA5A5A5A5 in the same cycle.
  - Without macro: RD1=0x1 in that cycle, 0xA5A5A5A5 on the next.
- Reset mid-run:
  - Write reg4=0x55 and issue rd=4, assert rst -> ready=0, busy=0.
  - After 32 cycles: reg4=0 and pending[4]=0.
  - Writes issued during CLEAR are ignored.
